// File: rtl/in_mem_loader.sv
// Stream-to-memory write front end: latches a load command, then turns each accepted beat into one registered memory write.
// Optional macro IN_MEM_LOADER_LAST_CHECK_EN enables the sticky s_last framing check on err.
module in_mem_loader #(
  parameter int AXI_HP_BIT = 64,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   base_addr,
  input  logic [ADDR_WIDTH:0]   beat_len,
  input  logic                  s_valid,
  input  logic [AXI_HP_BIT-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH:0]   wr_addr,
  output logic [AXI_HP_BIT-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Handshake: a beat transfers on a rising edge where s_valid and s_ready are
  // both high; s_ready is high only while loading and never depends on s_valid.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] addr_cnt;
  logic [ADDR_WIDTH:0] rem_cnt;
  logic                handshake;
  logic                cmd_accept;
  logic                final_beat;

  assign s_ready    = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign handshake  = s_valid & s_ready;
  assign cmd_accept = (state == ST_IDLE) & start;
  assign final_beat = (rem_cnt == ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (beat_len == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: if (handshake && final_beat) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
      rem_cnt  <= '0;
    end else if (cmd_accept) begin
      addr_cnt <= base_addr;
      rem_cnt  <= beat_len;
    end else if (handshake) begin
      addr_cnt <= addr_cnt + ONE;
      rem_cnt  <= rem_cnt - ONE;
    end
  end

  // wr_addr/wr_data hold their last value between writes; only wr_en pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= handshake;
      if (handshake) begin
        wr_addr <= addr_cnt;
        wr_data <= s_data;
      end
    end
  end

`ifdef IN_MEM_LOADER_LAST_CHECK_EN
  // s_last must be high on exactly the final beat; the transfer length is unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (cmd_accept) begin
      err <= 1'b0;
    end else if (handshake && (s_last != final_beat)) begin
      err <= 1'b1;
    end
  end
`else
  logic last_unused;
  assign last_unused = s_last;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_in_mem_loader.sv
// Self-checking bench for in_mem_loader: directed tests plus random transfers against a transaction-level model.
module tb_in_mem_loader;
  localparam int DW = 64;
  localparam int AW = 14;
  localparam int AMASK = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   base_addr = '0;
  logic [AW:0]   beat_len = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready, wr_en, busy, done, err;
  logic [AW:0]   wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  in_mem_loader #(.AXI_HP_BIT(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .beat_len(beat_len),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a command opens a window of beat_len accepted
  // beats; each accepted beat becomes one write one cycle later; the cycle
  // after the last write (or after a zero-length command) is the done cycle.
  bit          m_open;
  int          m_left;
  int          m_next_addr;
  bit          m_done;
  bit          m_wr;
  int          m_waddr;
  logic [DW-1:0] m_wdata;
  bit          m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_open = 0; m_left = 0; m_next_addr = 0; m_done = 0;
      m_wr = 0; m_waddr = 0; m_wdata = '0; m_err = 0;
    end else begin
      m_wr = 0;
      if (m_open) begin
        if (s_valid) begin
          m_wr = 1;
          m_waddr = m_next_addr;
          m_wdata = s_data;
`ifdef IN_MEM_LOADER_LAST_CHECK_EN
          if (s_last != (m_left == 1)) m_err = 1;
`endif
          m_next_addr = (m_next_addr + 1) & AMASK;
          m_left--;
          if (m_left == 0) begin
            m_open = 0;
            m_done = 1;
          end
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (start) begin
        m_err = 0;
        if (beat_len == 0) m_done = 1;
        else begin
          m_open = 1;
          m_left = int'(beat_len);
          m_next_addr = int'(beat_len) == 0 ? 0 : int'(base_addr);
        end
      end
    end
  end

  // Observed write log, used by the literal checks of directed tests.
  int          obs_addr[$];
  logic [DW-1:0] obs_data[$];

  always @(negedge clk) begin
    chk("s_ready", s_ready, m_open);
    chk("busy", busy, m_open | m_done);
    chk("done", done, m_done);
    chk("wr_en", wr_en, m_wr);
    chk("wr_addr", wr_addr, m_waddr[AW:0]);
    chk("wr_data", wr_data, m_wdata);
    chk("err", err, m_err);
    if (wr_en) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(wr_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int base, input int len);
    start = 1'b1;
    base_addr = base[AW:0];
    beat_len = len[AW:0];
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    obs_addr.delete();
    obs_data.delete();
  endtask

  initial begin
    int pat[6];
    int k;
    rst = 1'b1;
    idle(3);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_wr_addr", wr_addr, 0);
    rst = 1'b0;
    idle(2);

    // basic load with a fifth beat offered after the transfer
    clear_log();
    cmd(16'h0010, 4);
    for (int i = 0; i < 4; i++) beat(64'hA0 + i, i == 3);
    chk("overrun_not_ready", s_ready, 0);
    beat(64'hA4, 1'b0);
    idle(2);
    chk("basic_count", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      chk("basic_addr", obs_addr[i], 16'h0010 + i);
      chk("basic_data", obs_data[i], 64'hA0 + i);
    end

    // stalls: valid pattern 1,0,0,1,0,1
    clear_log();
    pat = '{1, 0, 0, 1, 0, 1};
    cmd(16'h0040, 3);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (pat[i] == 1) begin
        beat(64'hB0 + k, k == 2);
        k++;
      end else step();
    end
    idle(2);
    chk("stall_count", obs_addr.size(), 3);
    if (obs_addr.size() == 3) chk("stall_last_addr", obs_addr[2], 16'h0042);

    // address wrap
    clear_log();
    cmd(16'h7FFF, 2);
    beat(64'hC0, 1'b0);
    beat(64'hC1, 1'b1);
    idle(2);
    chk("wrap_count", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      chk("wrap_addr0", obs_addr[0], 16'h7FFF);
      chk("wrap_addr1", obs_addr[1], 16'h0000);
    end

    // zero length: done the next cycle, no writes
    clear_log();
    cmd(16'h0123, 0);
    chk("zero_done", done, 1);
    idle(2);
    chk("zero_count", obs_addr.size(), 0);

    // ignored start during LOAD
    clear_log();
    cmd(16'h0020, 4);
    beat(64'hD0, 1'b0);
    start = 1'b1; base_addr = 15'h0100; beat_len = 15'd2;
    beat(64'hD1, 1'b0);
    start = 1'b0;
    beat(64'hD2, 1'b0);
    beat(64'hD3, 1'b1);
    idle(2);
    chk("ign_count", obs_addr.size(), 4);
    if (obs_addr.size() == 4) chk("ign_addr3", obs_addr[3], 16'h0023);

    // reset mid-transfer
    clear_log();
    cmd(16'h0200, 8);
    beat(64'hE0, 1'b0);
    s_valid = 1'b1; s_data = 64'hE1;
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wr_addr", wr_addr, 0);
    chk("rst_mid_wr_data", wr_data, 0);
    s_valid = 1'b0;
    step();
    rst = 1'b0;
    idle(1);
    chk("rst_mid_count", obs_addr.size(), 1);
    clear_log();
    cmd(16'h0300, 3);
    for (int i = 0; i < 3; i++) beat(64'hF0 + i, i == 2);
    idle(2);
    chk("post_rst_count", obs_addr.size(), 3);
    if (obs_addr.size() == 3) chk("post_rst_addr0", obs_addr[0], 16'h0300);

    // s_last on beat 2 of 4
    clear_log();
    cmd(16'h0400, 4);
    for (int i = 0; i < 4; i++) beat(64'h50 + i, i == 1);
    idle(1);
`ifdef IN_MEM_LOADER_LAST_CHECK_EN
    chk("last_err_set", err, 1);
`else
    chk("last_err_off", err, 0);
`endif
    chk("last_count", obs_addr.size(), 4);
    cmd(16'h0500, 1);
    chk("last_err_clear", err, 0);
    beat(64'h60, 1'b1);
    idle(2);

    // random transfers
    for (int t = 0; t < 40; t++) begin
      int len;
      int cyc;
      len = $urandom_range(0, 12);
      cmd($urandom_range(0, AMASK), len);
      cyc = 0;
      while (cyc < 3 * len + 4) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data = {$urandom, $urandom};
        s_last = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) begin
          start = 1'b1;
          base_addr = 15'($urandom_range(0, AMASK));
          beat_len = 15'($urandom_range(0, 5));
        end
        step();
        start = 1'b0;
        cyc++;
      end
      s_valid = 1'b0;
      idle(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/in_mem_loader.md
# in_mem_loader

Write-side front end for the input feature-map memory. Accepts a load command (base address, beat count) and a 64-bit valid/ready beat stream from the AXI HP read path. Converts each accepted beat into one registered single-cycle write on the memory's `wr_en`/`wr_addr`/`wr_data` port. The convolution and max-pool engines read the memory only after `done`.

## Interface

**Parameters**
- `AXI_HP_BIT`, default 64: beat and memory word width.
- `ADDR_WIDTH`, default 14: memory address is `ADDR_WIDTH+1` bits wide, matching the memory write port. The beat count uses the same width.

**Ports**
- `clk`, in, 1: single clock for all logic.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: load command strobe. Sampled only in IDLE.
- `base_addr`, in, `ADDR_WIDTH+1`: first write address. Latched on an accepted `start`.
- `beat_len`, in, `ADDR_WIDTH+1`: number of beats to load. Latched on an accepted `start`. 0 is legal.
- `s_valid`, in, 1: stream beat valid.
- `s_data`, in, `AXI_HP_BIT`: stream beat data.
- `s_last`, in, 1: end-of-transfer marker from the source.
- `s_ready`, out, 1: loader accepts a beat.
- `wr_en`, out, 1: memory write strobe, registered.
- `wr_addr`, out, `ADDR_WIDTH+1`: memory write address, registered.
- `wr_data`, out, `AXI_HP_BIT`: memory write data, registered.
- `busy`, out, 1: high in LOAD and DONE.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: sticky framing error. See Configuration.

## Operation

**States:** IDLE, LOAD, DONE.

**IDLE**
- `s_ready`=0.
- `start`=1 and `beat_len`≠0 → LOAD. Latch `base_addr` into the address counter and `beat_len` into the remaining counter. Clear `err`.
- `start`=1 and `beat_len`=0 → DONE. No writes are issued. Clear `err`.

**LOAD**
- `s_ready`=1 combinationally.
- A handshake occurs when `s_valid` & `s_ready` are both high at a rising edge. On each handshake:
  - register `wr_en`=1, `wr_addr`=current address, `wr_data`=`s_data`;
  - increment the address;
  - decrement the remaining count.
- Without a handshake, `wr_en` registers 0. `wr_addr`/`wr_data` hold their last values.
- A handshake with remaining=1 → DONE.

**DONE**
- `done`=1 for exactly one cycle, `s_ready`=0.
- Unconditionally → IDLE.

**Rules**
- `start` outside IDLE is ignored. There is no queueing.
- Address arithmetic is modulo 2^(`ADDR_WIDTH+1`). `base_addr`=all-ones wraps to 0 on the next beat.
- The transfer length is governed only by `beat_len`. `s_last` never shortens or extends a transfer.
- Reset values: state IDLE, `s_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, counters 0.
- Reset asserted mid-transfer:
  - outputs return to reset values asynchronously;
  - any in-flight `wr_en` is dropped;
  - memory contents already written are left as they are;
  - the partial transfer is abandoned.

## Timing

- Write latency: a beat accepted at edge N is presented on `wr_*` during cycle N+1, with `wr_en` high for that single cycle.
- Throughput: one beat per cycle. Back-to-back handshakes produce back-to-back `wr_en` with consecutive addresses.
- `done` is high in the same cycle as the final `wr_en`. For `beat_len`=0, `done` is high in the cycle after `start` is sampled.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- The earliest next `start` is accepted in the cycle after `done`.
- `s_ready` falls in the cycle after the final handshake. A beat presented then is not consumed.

## Configuration

**`IN_MEM_LOADER_LAST_CHECK_EN`**
- **Defined:** `err` is set and stays high until the next accepted `start` if either occurs:
  - `s_last`=1 on a handshake that is not the final beat;
  - `s_last`=0 on the final beat's handshake.
  
  The transfer still completes exactly `beat_len` beats.
- **Undefined:** `s_last` is ignored and `err` is tied 0. The port list is unchanged.

## Test plan

- **Basic load:** reset, then `start` with base=0x0010, len=4, and 4 beats 0xA0..0xA3 with `s_valid` held high → `wr_en` high 4 consecutive cycles at addresses 0x10..0x13 with matching data. `done` is high alongside the 4th `wr_en`, then `busy`=0.
- **Stalls:** len=3, `s_valid` toggled 1,0,0,1,0,1 → exactly 3 writes at consecutive addresses, and `wr_en`=0 in stall cycles. `done` coincides with the third write.
- **Wrap and zero length:** base=0x7FFF, len=2 → writes at 0x7FFF then 0x0000. A separate `start` with len=0 → `done` the next cycle, no `wr_en`.
- **Ignored start and overrun:** a second `start` (base=0x100) during LOAD is ignored, and addresses continue from the first base. A 5th beat offered after len=4 is not accepted (`s_ready`=0).
- **Reset mid-transfer:** assert `rst` after 2 of 8 beats → all outputs 0 immediately, no further `wr_en`. A new `start` after release loads normally from its own base.
- **`s_last` check (`IN_MEM_LOADER_LAST_CHECK_EN` defined):** len=4 with `s_last` on beat 2 → `err`=1, yet 4 writes still issue and `done` still pulses. `err` clears on the next `start`. With the macro undefined, the same stimulus gives `err`=0.
